// File: rtl/operand_fetch_if.sv
// Bundle of issue, register-file read, writeback and ALU-side signals for operand_fetch.
// slave is the operand_fetch view; master is the surrounding pipeline view.
interface operand_fetch_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned OP_W   = 4
) ();
  logic              issue_valid;
  logic              issue_ready;
  logic [OP_W-1:0]   issue_op;
  logic [ADDR_W-1:0] issue_rs1;
  logic [ADDR_W-1:0] issue_rs2;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_wr;
  logic [ADDR_W-1:0] rf_addr1;
  logic [ADDR_W-1:0] rf_addr2;
  logic [DATA_W-1:0] rf_data1;
  logic [DATA_W-1:0] rf_data2;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              ex_valid;
  logic              ex_ready;
  logic [OP_W-1:0]   ex_op;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [ADDR_W-1:0] ex_rd;
  logic              ex_wr;

  modport slave (
    input  issue_valid, issue_op, issue_rs1, issue_rs2, issue_rd, issue_wr,
    input  rf_data1, rf_data2, wb_en, wb_addr, wb_data, ex_ready,
    output issue_ready, rf_addr1, rf_addr2, ex_valid, ex_op, ex_a, ex_b, ex_rd, ex_wr
  );

  modport master (
    output issue_valid, issue_op, issue_rs1, issue_rs2, issue_rd, issue_wr,
    output rf_data1, rf_data2, wb_en, wb_addr, wb_data, ex_ready,
    input  issue_ready, rf_addr1, rf_addr2, ex_valid, ex_op, ex_a, ex_b, ex_rd, ex_wr
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: RF read, scoreboard hazard check, one registered bundle to the ALU.
// Define OPFETCH_BYPASS_EN to forward the same-cycle writeback instead of stalling on it.
module operand_fetch #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned OP_W   = 4
) (
  input logic            clk,
  input logic            rst,
  operand_fetch_if.slave bus
);
  localparam int unsigned NumRegs = 1 << ADDR_W;

  logic [NumRegs-1:0] busy_q, busy_d;
  logic               ex_valid_q;
  logic [OP_W-1:0]    ex_op_q;
  logic [DATA_W-1:0]  ex_a_q, ex_b_q;
  logic [ADDR_W-1:0]  ex_rd_q;
  logic               ex_wr_q;

  logic              byp1, byp2, bypd;
  logic              blk1, blk2, waw, hazard, accept;
  logic [DATA_W-1:0] src_a, src_b;

  assign bus.rf_addr1 = bus.issue_rs1;
  assign bus.rf_addr2 = bus.issue_rs2;

  always_comb begin
`ifdef OPFETCH_BYPASS_EN
    byp1 = bus.wb_en && (bus.wb_addr == bus.issue_rs1);
    byp2 = bus.wb_en && (bus.wb_addr == bus.issue_rs2);
    bypd = bus.wb_en && (bus.wb_addr == bus.issue_rd);
`else
    // Without forwarding a busy register is only usable once the RF holds the new value.
    byp1 = 1'b0;
    byp2 = 1'b0;
    bypd = 1'b0;
`endif
  end

  always_comb begin
    src_a = '0;
    if (bus.issue_rs1 != '0) src_a = byp1 ? bus.wb_data : bus.rf_data1;
    src_b = '0;
    if (bus.issue_rs2 != '0) src_b = byp2 ? bus.wb_data : bus.rf_data2;
  end

  assign blk1   = (bus.issue_rs1 != '0) && busy_q[bus.issue_rs1] && !byp1;
  assign blk2   = (bus.issue_rs2 != '0) && busy_q[bus.issue_rs2] && !byp2;
  assign waw    = bus.issue_wr && (bus.issue_rd != '0) && busy_q[bus.issue_rd] && !bypd;
  assign hazard = bus.issue_valid && (blk1 || blk2 || waw);

  assign bus.issue_ready = (!ex_valid_q || bus.ex_ready) && !hazard;
  assign accept          = bus.issue_valid && bus.issue_ready;

  // Clear first so a same-cycle set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (bus.wb_en && (bus.wb_addr != '0)) busy_d[bus.wb_addr] = 1'b0;
    if (accept && bus.issue_wr && (bus.issue_rd != '0)) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= '0;
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_rd_q    <= '0;
      ex_wr_q    <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (accept) begin
        ex_valid_q <= 1'b1;
        ex_op_q    <= bus.issue_op;
        ex_a_q     <= src_a;
        ex_b_q     <= src_b;
        ex_rd_q    <= bus.issue_rd;
        ex_wr_q    <= bus.issue_wr;
      end else if (bus.ex_ready) begin
        ex_valid_q <= 1'b0;
      end
    end
  end

  assign bus.ex_valid = ex_valid_q;
  assign bus.ex_op    = ex_op_q;
  assign bus.ex_a     = ex_a_q;
  assign bus.ex_b     = ex_b_q;
  assign bus.ex_rd    = ex_rd_q;
  assign bus.ex_wr    = ex_wr_q;
endmodule
